// File: rtl/dmi_arbiter.sv
// Arbitrates several DTM DMI masters onto the single DMI port of the debug module.
// One transaction in flight; round-robin or fixed priority; optional response timeout.
module dmi_arbiter #(
  parameter int NR_PORTS   = 2,
  parameter int DMI_ABITS  = 7,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 0,
  parameter int IDX_W      = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NR_PORTS-1:0]           port_en_i,
  input  logic [NR_PORTS-1:0]           req_valid_i,
  output logic [NR_PORTS-1:0]           req_ready_o,
  input  logic [NR_PORTS*DMI_ABITS-1:0] req_addr_i,
  input  logic [NR_PORTS*2-1:0]         req_op_i,
  input  logic [NR_PORTS*32-1:0]        req_data_i,
  output logic [NR_PORTS-1:0]           resp_valid_o,
  input  logic [NR_PORTS-1:0]           resp_ready_i,
  output logic [31:0]                   resp_data_o,
  output logic [1:0]                    resp_resp_o,
  output logic                          dmi_req_valid_o,
  input  logic                          dmi_req_ready_i,
  output logic [DMI_ABITS-1:0]          dmi_req_addr_o,
  output logic [1:0]                    dmi_req_op_o,
  output logic [31:0]                   dmi_req_data_o,
  input  logic                          dmi_resp_valid_i,
  output logic                          dmi_resp_ready_o,
  input  logic [31:0]                   dmi_resp_data_i,
  input  logic [1:0]                    dmi_resp_resp_i,
  output logic                          busy_o,
  output logic [IDX_W-1:0]              owner_o,
  output logic [2:0]                    state_o
);

  // Handshake rule on every channel: a transfer happens on the rising clk_i edge
  // where valid and ready are both high; valid never waits for ready.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, owner_q, win_idx;
  logic                   win_found;
  logic [NR_PORTS-1:0]    elig, hi_mask, sel;
  logic [DMI_ABITS-1:0]   addr_q;
  logic [1:0]             op_q;
  logic [31:0]            data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   timeout_hit;

  logic [DMI_ABITS-1:0]   addr_arr [NR_PORTS];
  logic [1:0]             op_arr   [NR_PORTS];
  logic [31:0]            data_arr [NR_PORTS];

  for (genvar k = 0; k < NR_PORTS; k++) begin : g_unpack
    assign addr_arr[k] = req_addr_i[k*DMI_ABITS +: DMI_ABITS];
    assign op_arr[k]   = req_op_i[k*2 +: 2];
    assign data_arr[k] = req_data_i[k*32 +: 32];
  end

  assign elig        = req_valid_i & port_en_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= CNT_LAST);

  // Round-robin: prefer eligible ports at or above the pointer, else wrap to the lowest.
  always_comb begin
    hi_mask   = '0;
    win_idx   = '0;
    win_found = |elig;
    for (int i = 0; i < NR_PORTS; i++) begin
      hi_mask[i] = (FIXED_PRIO == 0) && (IDX_W'(i) >= ptr_q);
    end
    sel = (|(elig & hi_mask)) ? (elig & hi_mask) : elig;
    for (int i = NR_PORTS - 1; i >= 0; i--) begin
      if (sel[i]) win_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_found) state_d = ST_SEND;
      ST_SEND:  if (dmi_req_ready_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (dmi_resp_valid_i && resp_ready_i[owner_q]) state_d = ST_IDLE;
        else if (timeout_hit && !dmi_resp_valid_i)     state_d = ST_ERR;
      end
      ST_ERR:   if (resp_ready_i[owner_q]) state_d = ST_DRAIN;
      ST_DRAIN: if (dmi_resp_valid_i || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o      = '0;
    resp_valid_o     = '0;
    resp_data_o      = '0;
    resp_resp_o      = '0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: if (win_found) req_ready_o[win_idx] = 1'b1;
      ST_SEND: dmi_req_valid_o = 1'b1;
      ST_WAIT: begin
        resp_valid_o[owner_q] = dmi_resp_valid_i;
        dmi_resp_ready_o      = resp_ready_i[owner_q];
        resp_data_o           = dmi_resp_data_i;
        resp_resp_o           = dmi_resp_resp_i;
      end
      ST_ERR: begin
        resp_valid_o[owner_q] = 1'b1;
        resp_resp_o           = 2'b10;
      end
      ST_DRAIN: dmi_resp_ready_o = 1'b1;
      default: ;
    endcase
  end

  // Captured request, owner, pointer and the shared WAIT/DRAIN cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (win_found) begin
            addr_q  <= addr_arr[win_idx];
            op_q    <= op_arr[win_idx];
            data_q  <= data_arr[win_idx];
            owner_q <= win_idx;
            ptr_q   <= (win_idx == IDX_W'(NR_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
          end
        end
        ST_SEND:  if (dmi_req_ready_i) cnt_q <= '0;
        ST_ERR:   if (resp_ready_i[owner_q]) cnt_q <= '0;
        ST_WAIT, ST_DRAIN: if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign dmi_req_addr_o = addr_q;
  assign dmi_req_op_o   = op_q;
  assign dmi_req_data_o = data_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign owner_o        = owner_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: a round-robin and a fixed-priority instance share upstream
// stimulus; each has its own DM responder and expected grant/response queues.
module tb_dmi_arbiter;
  localparam int NP = 2;
  localparam int AW = 7;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NP-1:0]      port_en, req_valid, resp_ready;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*2-1:0]    req_op;
  logic [NP*32-1:0]   req_data;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [NP-1:0]  req_ready      [2];
  logic [NP-1:0]  resp_valid     [2];
  logic [31:0]    resp_data      [2];
  logic [1:0]     resp_resp      [2];
  logic           dmi_req_valid  [2];
  logic           dmi_req_ready  [2];
  logic [AW-1:0]  dmi_req_addr   [2];
  logic [1:0]     dmi_req_op     [2];
  logic [31:0]    dmi_req_data   [2];
  logic           dmi_resp_valid [2];
  logic           dmi_resp_ready [2];
  logic [31:0]    dmi_resp_data  [2];
  logic [1:0]     dmi_resp_resp  [2];
  logic           busy           [2];
  logic [0:0]     owner          [2];
  logic [2:0]     state          [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmi_arbiter #(
      .NR_PORTS(NP), .DMI_ABITS(AW), .FIXED_PRIO(g), .TIMEOUT(TO)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .port_en_i(port_en),
      .req_valid_i(req_valid), .req_ready_o(req_ready[g]),
      .req_addr_i(req_addr), .req_op_i(req_op), .req_data_i(req_data),
      .resp_valid_o(resp_valid[g]), .resp_ready_i(resp_ready),
      .resp_data_o(resp_data[g]), .resp_resp_o(resp_resp[g]),
      .dmi_req_valid_o(dmi_req_valid[g]), .dmi_req_ready_i(dmi_req_ready[g]),
      .dmi_req_addr_o(dmi_req_addr[g]), .dmi_req_op_o(dmi_req_op[g]),
      .dmi_req_data_o(dmi_req_data[g]),
      .dmi_resp_valid_i(dmi_resp_valid[g]), .dmi_resp_ready_o(dmi_resp_ready[g]),
      .dmi_resp_data_i(dmi_resp_data[g]), .dmi_resp_resp_i(dmi_resp_resp[g]),
      .busy_o(busy[g]), .owner_o(owner[g]), .state_o(state[g])
    );
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q0 [$];
  logic [34:0] exp_q1 [$];
  int exp_gnt_q0 [$];
  int exp_gnt_q1 [$];

  function automatic void chk(input string name, input int g, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, g, act, exp);
    end
  endfunction

  function automatic void push_exp(input int g, input int port, input logic [1:0] r,
                                   input logic [31:0] d);
    if (g == 0) begin
      exp_gnt_q0.push_back(port);
      exp_q0.push_back({1'(port), r, d});
    end else begin
      exp_gnt_q1.push_back(port);
      exp_q1.push_back({1'(port), r, d});
    end
  endfunction

  // monitor: grants, owner after grant, upstream responses
  bit  own_pend [2];
  int  own_exp  [2];
  initial begin
    own_pend[0] = 1'b0;
    own_pend[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int g = 0; g < 2; g++) begin
          if (own_pend[g]) begin
            chk("owner", g, 64'(owner[g]), 64'(own_exp[g]));
            own_pend[g] = 1'b0;
          end
          for (int k = 0; k < NP; k++) begin
            if (req_valid[k] && req_ready[g][k]) begin
              int e;
              if ((g == 0 ? exp_gnt_q0.size() : exp_gnt_q1.size()) == 0) begin
                checks++; errors++;
                $display("FAIL grant_unexpected dut%0d actual=port%0d expected=none", g, k);
              end else begin
                e = (g == 0) ? exp_gnt_q0.pop_front() : exp_gnt_q1.pop_front();
                chk("grant", g, 64'(k), 64'(e));
                own_pend[g] = 1'b1;
                own_exp[g]  = k;
              end
            end
            if (resp_valid[g][k] && resp_ready[k]) begin
              logic [34:0] act, e;
              act = {1'(k), resp_resp[g], resp_data[g]};
              if ((g == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                checks++; errors++;
                $display("FAIL resp_unexpected dut%0d actual=%0h expected=none", g, act);
              end else begin
                e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk("resp", g, 64'(act), 64'(e));
              end
            end
          end
        end
      end
    end
  end

  // ---------------- DM responder (both instances) ----------------
  int          req_delay, resp_delay;
  logic [31:0] dm_pattern;
  int          wcnt [2];
  int          rcnt [2];
  bit          pend [2];
  bit          rq_hs [2];
  bit          rs_hs [2];
  logic [31:0] cap [2];

  initial begin
    for (int g = 0; g < 2; g++) begin
      dmi_req_ready[g] = 1'b0; dmi_resp_valid[g] = 1'b0;
      dmi_resp_data[g] = '0;   dmi_resp_resp[g]  = '0;
      wcnt[g] = 0; rcnt[g] = 0; pend[g] = 1'b0; cap[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        rq_hs[g] = dmi_req_valid[g] && dmi_req_ready[g];
        rs_hs[g] = dmi_resp_valid[g] && dmi_resp_ready[g];
        if (rq_hs[g])
          cap[g] = dm_pattern ^ dmi_req_data[g] ^ {23'b0, dmi_req_addr[g], dmi_req_op[g]};
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (!rst_n) begin
          dmi_req_ready[g] = 1'b0; dmi_resp_valid[g] = 1'b0;
          wcnt[g] = 0; rcnt[g] = 0; pend[g] = 1'b0;
        end else begin
          if (rq_hs[g]) begin
            dmi_req_ready[g] = 1'b0; pend[g] = 1'b1; rcnt[g] = 0; wcnt[g] = 0;
          end else if (dmi_req_valid[g] && !dmi_req_ready[g]) begin
            if (wcnt[g] >= req_delay) dmi_req_ready[g] = 1'b1;
            else wcnt[g]++;
          end
          if (rs_hs[g]) dmi_resp_valid[g] = 1'b0;
          if (pend[g]) begin
            if (rcnt[g] >= resp_delay) begin
              dmi_resp_valid[g] = 1'b1; dmi_resp_data[g] = cap[g];
              dmi_resp_resp[g] = 2'b00; pend[g] = 1'b0;
            end else rcnt[g]++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept();
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready[0])) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL accept_timeout actual=no_grant expected=grant");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1]) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int rr_seq [5] = '{0, 1, 0, 1, 1};
  int fp_seq [5] = '{0, 0, 0, 0, 1};
  int lat;

  initial begin
    rst_n = 1'b0; port_en = 2'b11; req_valid = 2'b00; resp_ready = 2'b11;
    req_addr = {7'h31, 7'h20}; req_op = {2'd2, 2'd1}; req_data = {32'h0000_5A00, 32'h0};
    req_delay = 0; resp_delay = 0; dm_pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy", g, 64'(busy[g]), 64'd0);
      chk("rst_dmi_req_valid", g, 64'(dmi_req_valid[g]), 64'd0);
      chk("rst_dmi_resp_ready", g, 64'(dmi_resp_ready[g]), 64'd0);
      chk("rst_req_ready", g, 64'(req_ready[g]), 64'd0);
      chk("rst_resp_valid", g, 64'(resp_valid[g]), 64'd0);
      chk("rst_owner", g, 64'(owner[g]), 64'd0);
      chk("rst_dmi_req_addr", g, 64'(dmi_req_addr[g]), 64'd0);
    end
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    // contention: RR alternates, fixed priority keeps port0 until it drops
    dm_pattern = 32'h1000_0000; req_delay = 0; resp_delay = 1;
    for (int i = 0; i < 5; i++) begin
      push_exp(0, rr_seq[i], 2'b00, (rr_seq[i] == 1) ? 32'h1000_5AC6 : 32'h1000_0081);
      push_exp(1, fp_seq[i], 2'b00, (fp_seq[i] == 1) ? 32'h1000_5AC6 : 32'h1000_0081);
    end
    req_valid = 2'b11;
    repeat (4) wait_accept();
    req_valid[0] = 1'b0;
    wait_accept();
    req_valid[1] = 1'b0;
    wait_idle();

    // single read from port0, DM ready after 2 cycles
    req_addr = {7'h31, 7'h11}; dm_pattern = 32'hDEAD_BEAA; req_delay = 2; resp_delay = 0;
    push_exp(0, 0, 2'b00, 32'hDEAD_BEEF);
    push_exp(1, 0, 2'b00, 32'hDEAD_BEEF);
    req_valid = 2'b01;
    wait_accept();
    req_valid = 2'b00;
    wait_idle();
    for (int g = 0; g < 2; g++) chk("busy_after_single", g, 64'(busy[g]), 64'd0);
    req_addr = {7'h31, 7'h20};

    // enables: only port1 eligible; disabling it mid-WAIT does not abort
    port_en = 2'b10; dm_pattern = 32'h2000_0000; req_delay = 0; resp_delay = 6;
    push_exp(0, 1, 2'b00, 32'h2000_5AC6);
    push_exp(1, 1, 2'b00, 32'h2000_5AC6);
    req_valid = 2'b11;
    wait_accept();
    req_valid = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    for (int g = 0; g < 2; g++) chk("state_wait", g, 64'(state[g]), 64'd2);
    port_en = 2'b00;
    wait_idle();
    port_en = 2'b11;

    // timeout: DM answers far too late; error to owner, late response swallowed
    dm_pattern = 32'h5555_0000; req_delay = 0; resp_delay = 19;
    push_exp(0, 1, 2'b10, 32'h0);
    push_exp(1, 1, 2'b10, 32'h0);
    req_valid = 2'b10;
    wait_accept();
    req_valid = 2'b00;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (resp_valid[0][1]) lat = i;
    end
    chk("timeout_latency", 0, 64'(lat), 64'd17);
    wait_idle();
    repeat (4) begin @(posedge clk); #1; end
    for (int g = 0; g < 2; g++) begin
      chk("late_resp_swallowed", g, 64'(dmi_resp_valid[g]), 64'd0);
      chk("busy_after_timeout", g, 64'(busy[g]), 64'd0);
    end

    // reset while in SEND, then a fresh request from both ports
    req_delay = 5; resp_delay = 0;
    exp_gnt_q0.push_back(0);
    exp_gnt_q1.push_back(0);
    req_valid = 2'b01;
    wait_accept();
    req_valid = 2'b00;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_send_dmi_req_valid", g, 64'(dmi_req_valid[g]), 64'd0);
      chk("rst_send_busy", g, 64'(busy[g]), 64'd0);
      chk("rst_send_state", g, 64'(state[g]), 64'd0);
    end
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    dm_pattern = 32'h3000_0000; req_delay = 0; resp_delay = 1;
    push_exp(0, 0, 2'b00, 32'h3000_0081);
    push_exp(1, 0, 2'b00, 32'h3000_0081);
    req_valid = 2'b11;
    wait_accept();
    req_valid = 2'b00;
    wait_idle();
    repeat (5) begin @(posedge clk); #1; end

    chk("exp_q0_empty", 0, 64'(exp_q0.size()), 64'd0);
    chk("exp_q1_empty", 1, 64'(exp_q1.size()), 64'd0);
    chk("exp_gnt_q0_empty", 0, 64'(exp_gnt_q0.size()), 64'd0);
    chk("exp_gnt_q1_empty", 1, 64'(exp_gnt_q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
